// File: rtl/tart_capture_pkg.sv
// tart_capture_pkg: shared configuration for the antenna-capture path.
// Holds the default widths and ratios so that the capture front-end, the
// storage scheduler and the SPI readback logic all agree on them.
//   TART_AXNUM : antenna channels per sample (sample width)
//   TART_RATIO : fabric clocks per receiver sample period
//   TART_RBITS : phase-select width, 2**TART_RBITS >= TART_RATIO
//   TART_ABITS : capture FIFO address width, depth = 2**TART_ABITS
package tart_capture_pkg;

    localparam int unsigned TART_AXNUM = 24;
    localparam int unsigned TART_RATIO = 6;
    localparam int unsigned TART_RBITS = 3;
    localparam int unsigned TART_ABITS = 9;

endpackage

// File: rtl/tart_capture_if.sv
// tart_capture_if: control, capture and FIFO read-out bundle of tart_capture.
//   en_i     capture enable
//   dbg_i    select counter test pattern instead of antenna data
//   dly_i    sample phase within each receiver period
//   clr_i    synchronous flush of FIFO, overflow flag and pattern counter
//   ant_i    raw antenna pins (asynchronous to the fabric clock)
//   rd_i     FIFO read request
//   dat_o    read data, vld_o marks the cycle it is fresh
//   empty_o / full_o / level_o  FIFO status
//   oflow_o  sticky overflow flag
//   stb_o    one-cycle strobe per capture event
// Modports: master drives the requests (scheduler/bench), slave is the DUT.
interface tart_capture_if
    import tart_capture_pkg::*;
#(
    parameter int unsigned AXNUM = TART_AXNUM,
    parameter int unsigned RBITS = TART_RBITS,
    parameter int unsigned ABITS = TART_ABITS
);

    logic             en_i;
    logic             dbg_i;
    logic [RBITS-1:0] dly_i;
    logic             clr_i;
    logic [AXNUM-1:0] ant_i;
    logic             rd_i;
    logic [AXNUM-1:0] dat_o;
    logic             vld_o;
    logic             empty_o;
    logic             full_o;
    logic [ABITS:0]   level_o;
    logic             oflow_o;
    logic             stb_o;

    modport master (
        output en_i, dbg_i, dly_i, clr_i, ant_i, rd_i,
        input  dat_o, vld_o, empty_o, full_o, level_o, oflow_o, stb_o
    );

    modport slave (
        input  en_i, dbg_i, dly_i, clr_i, ant_i, rd_i,
        output dat_o, vld_o, empty_o, full_o, level_o, oflow_o, stb_o
    );

endinterface

// File: rtl/tart_capture_fifo.sv
// tart_capture_fifo: synchronous FIFO buffering captured samples.
//   clk, rst : fabric clock, asynchronous active-high reset
//   clr      : synchronous flush (pointers, level, flags)
//   wr/wdata : write request and data; accepted when not full or when a read
//              is accepted in the same cycle
//   rd       : read request, ignored while empty or during clr
//   rdata    : registered read data, holds its value between reads
//   vld      : one-cycle strobe, rdata was updated by the previous edge
//   empty/full/level : registered occupancy status
module tart_capture_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned ABITS = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd,
    output logic [WIDTH-1:0] rdata,
    output logic             vld,
    output logic             empty,
    output logic             full,
    output logic [ABITS:0]   level
);

    localparam logic [ABITS:0] DEPTH = {1'b1, {ABITS{1'b0}}};

    logic [WIDTH-1:0] mem [2**ABITS];
    logic [ABITS-1:0] wptr;
    logic [ABITS-1:0] rptr;
    logic             rd_ok;
    logic             wr_ok;
    logic [ABITS:0]   level_nxt;

    always_comb begin
        rd_ok = rd && !empty && !clr;
        // At full, a same-cycle read frees the slot the write lands in.
        wr_ok = wr && !clr && (!full || rd_ok);
        level_nxt = level;
        case ({wr_ok, rd_ok})
            2'b10:   level_nxt = level + 1'b1;
            2'b01:   level_nxt = level - 1'b1;
            default: level_nxt = level;
        endcase
    end

    // Memory kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr] <= wdata;
        end
    end

    // At full with read+write, wptr==rptr: the read sees the old entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
            vld   <= 1'b0;
            rdata <= '0;
        end else if (clr) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
            vld   <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_ok) begin
                rptr  <= rptr + 1'b1;
                rdata <= mem[rptr];
            end
            vld   <= rd_ok;
            level <= level_nxt;
            empty <= (level_nxt == '0);
            full  <= (level_nxt == DEPTH);
        end
    end

endmodule

// File: rtl/tart_capture.sv
// tart_capture: antenna-capture front-end.
// Synchronises the raw antenna bus into the fabric clock, samples it once per
// receiver period at a programmable phase, optionally substitutes a counter
// test pattern, and buffers samples in tart_capture_fifo.
//   clk_i : fabric clock (receiver rate x RATIO)
//   rst_i : asynchronous active-high reset
//   bus   : tart_capture_if slave (controls, antenna pins, FIFO read-out)
module tart_capture
    import tart_capture_pkg::*;
#(
    parameter int unsigned AXNUM = TART_AXNUM,
    parameter int unsigned RATIO = TART_RATIO,
    parameter int unsigned RBITS = TART_RBITS,
    parameter int unsigned ABITS = TART_ABITS
) (
    input  logic           clk_i,
    input  logic           rst_i,
    tart_capture_if.slave  bus
);

    localparam logic [RBITS-1:0] PH_MAX = RBITS'(RATIO - 1);

    logic [AXNUM-1:0] s1;
    logic [AXNUM-1:0] s2;
    logic [AXNUM-1:0] pat;
    logic [AXNUM-1:0] sample;
    logic [RBITS-1:0] ph;
    logic [RBITS-1:0] dly_r;
    logic [RBITS-1:0] dly_in;
    logic [RBITS-1:0] dly_eff;
    logic             dbg_r;
    logic             dbg_eff;
    logic             ph0;
    logic             cap;
    logic             wr;
    logic             drop;
    logic             full;
    logic             stb;
    logic             oflow;

    // Two-flop synchroniser; data path only, no reset needed.
    always_ff @(posedge clk_i) begin
        s1 <= bus.ant_i;
        s2 <= s1;
    end

    // dly_r/dbg_r are reloaded at ph==0; the value being loaded already
    // governs that ph==0 edge, so a new phase never yields two captures in
    // one receiver period.
    always_comb begin
        ph0     = (ph == '0);
        dly_in  = (bus.dly_i > PH_MAX) ? PH_MAX : bus.dly_i;
        dly_eff = ph0 ? dly_in : dly_r;
        dbg_eff = ph0 ? bus.dbg_i : dbg_r;
        cap     = bus.en_i && (ph == dly_eff);
        sample  = dbg_eff ? pat : s2;
        wr      = cap && !bus.clr_i;
        // rd_i while full is always an accepted read.
        drop    = wr && full && !bus.rd_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ph    <= '0;
            dly_r <= '0;
            dbg_r <= 1'b0;
            pat   <= '0;
            stb   <= 1'b0;
            oflow <= 1'b0;
        end else begin
            if (!bus.en_i) begin
                ph <= '0;
            end else if (ph == PH_MAX) begin
                ph <= '0;
            end else begin
                ph <= ph + 1'b1;
            end
            if (ph0) begin
                dly_r <= dly_in;
                dbg_r <= bus.dbg_i;
            end
            stb <= cap;
            if (bus.clr_i) begin
                pat   <= '0;
                oflow <= 1'b0;
            end else begin
                if (cap && dbg_eff) begin
                    pat <= pat + 1'b1;
                end
                if (drop) begin
                    oflow <= 1'b1;
                end
            end
        end
    end

    assign bus.stb_o   = stb;
    assign bus.oflow_o = oflow;
    assign bus.full_o  = full;

    tart_capture_fifo #(
        .WIDTH (AXNUM),
        .ABITS (ABITS)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .clr   (bus.clr_i),
        .wr    (wr),
        .wdata (sample),
        .rd    (bus.rd_i),
        .rdata (bus.dat_o),
        .vld   (bus.vld_o),
        .empty (bus.empty_o),
        .full  (full),
        .level (bus.level_o)
    );

endmodule

// File: tb/tb_tart_capture.sv
// tb_tart_capture: directed bench for tart_capture (AXNUM=24, RATIO=6,
// RBITS=3, ABITS=2 so that full/overflow are reached quickly).
module tb_tart_capture;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    tart_capture_if #(.AXNUM(24), .RBITS(3), .ABITS(2)) bus ();

    tart_capture #(
        .AXNUM (24),
        .RATIO (6),
        .RBITS (3),
        .ABITS (2)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        bus.en_i  = 1'b0;
        bus.dbg_i = 1'b0;
        bus.dly_i = 3'd0;
        bus.clr_i = 1'b0;
        bus.ant_i = 24'hA5A5A5;
        bus.rd_i  = 1'b0;
        repeat (4) tick();
        rst = 1'b0;
        tick();

        check("rst_empty", 32'(bus.empty_o), 32'd1);
        check("rst_full",  32'(bus.full_o),  32'd0);
        check("rst_level", 32'(bus.level_o), 32'd0);
        check("rst_oflow", 32'(bus.oflow_o), 32'd0);
        check("rst_vld",   32'(bus.vld_o),   32'd0);
        check("rst_stb",   32'(bus.stb_o),   32'd0);
        check("rst_dat",   32'(bus.dat_o),   32'd0);

        // Real data, phase 2: edge k sees ph=(k-1)%6, capture when k%6==3.
        bus.dly_i = 3'd2;
        bus.en_i  = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            tick();
            check("t1_stb", 32'(bus.stb_o), 32'(k % 6 == 3));
            if (k % 6 == 3) check("t1_level", 32'(bus.level_o), 32'(k / 6 + 1));
        end
        bus.en_i = 1'b0;
        bus.rd_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t1_vld",   32'(bus.vld_o),   32'd1);
            check("t1_dat",   32'(bus.dat_o),   32'hA5A5A5);
            check("t1_lvl_rd", 32'(bus.level_o), 32'(2 - i));
        end
        bus.rd_i = 1'b0;
        tick();
        check("t1_vld_off", 32'(bus.vld_o),   32'd0);
        check("t1_hold",    32'(bus.dat_o),   32'hA5A5A5);
        check("t1_empty",   32'(bus.empty_o), 32'd1);

        // Debug pattern, phase 0, then phase 4 requested mid-period.
        bus.dbg_i = 1'b1;
        bus.dly_i = 3'd0;
        bus.en_i  = 1'b1;
        for (int k = 1; k <= 14; k++) tick();
        check("t2_level3", 32'(bus.level_o), 32'd3);
        bus.dly_i = 3'd4;
        for (int k = 15; k <= 24; k++) begin
            tick();
            check("t2_stb_dly", 32'(bus.stb_o), 32'(k == 23));
        end
        check("t2_level4", 32'(bus.level_o), 32'd4);
        check("t2_full",   32'(bus.full_o),  32'd1);
        bus.en_i = 1'b0;
        bus.rd_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t2_vld", 32'(bus.vld_o), 32'd1);
            check("t2_pat", 32'(bus.dat_o), 32'(i));
        end
        bus.rd_i = 1'b0;
        tick();
        bus.en_i = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("t2_stb_ph4", 32'(bus.stb_o), 32'(k == 5));
        end
        bus.en_i = 1'b0;
        bus.rd_i = 1'b1;
        tick();
        check("t2_pat4", 32'(bus.dat_o), 32'd4);
        bus.rd_i = 1'b0;
        tick();
        check("t2_empty", 32'(bus.empty_o), 32'd1);

        // Overflow: five captures into a four-deep FIFO.
        bus.clr_i = 1'b1;
        tick();
        bus.clr_i = 1'b0;
        bus.dly_i = 3'd0;
        bus.en_i  = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            tick();
            if (k == 19) begin
                check("t3_level4", 32'(bus.level_o), 32'd4);
                check("t3_full",   32'(bus.full_o),  32'd1);
                check("t3_no_of",  32'(bus.oflow_o), 32'd0);
            end
        end
        check("t3_oflow", 32'(bus.oflow_o), 32'd1);
        check("t3_lvl",   32'(bus.level_o), 32'd4);
        bus.en_i = 1'b0;
        bus.rd_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t3_dat", 32'(bus.dat_o), 32'(i));
        end
        tick();
        check("t3_rd_empty_vld", 32'(bus.vld_o),   32'd0);
        check("t3_rd_empty_lvl", 32'(bus.level_o), 32'd0);
        check("t3_rd_empty_dat", 32'(bus.dat_o),   32'd3);
        bus.rd_i = 1'b0;
        check("t3_oflow_sticky", 32'(bus.oflow_o), 32'd1);
        bus.clr_i = 1'b1;
        tick();
        bus.clr_i = 1'b0;
        check("t3_clr_oflow", 32'(bus.oflow_o), 32'd0);
        check("t3_clr_level", 32'(bus.level_o), 32'd0);
        check("t3_clr_empty", 32'(bus.empty_o), 32'd1);

        // Full FIFO, read on the capture edge; pattern restarts at 0 after clr.
        bus.en_i = 1'b1;
        for (int k = 1; k <= 24; k++) tick();
        check("t4_full", 32'(bus.full_o), 32'd1);
        bus.rd_i = 1'b1;
        tick();
        bus.rd_i = 1'b0;
        bus.en_i = 1'b0;
        check("t4_vld",   32'(bus.vld_o),   32'd1);
        check("t4_dat",   32'(bus.dat_o),   32'd0);
        check("t4_level", 32'(bus.level_o), 32'd4);
        check("t4_oflow", 32'(bus.oflow_o), 32'd0);
        check("t4_full2", 32'(bus.full_o),  32'd1);
        bus.rd_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("t4_order", 32'(bus.dat_o), 32'(i));
        end
        bus.rd_i = 1'b0;
        tick();

        // Phase request beyond RATIO-1 clamps to ph=5.
        bus.dbg_i = 1'b0;
        bus.dly_i = 3'd7;
        bus.ant_i = 24'h5A5A5A;
        repeat (3) tick();
        bus.en_i = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("t5_stb", 32'(bus.stb_o), 32'(k == 6));
        end
        check("t5_level", 32'(bus.level_o), 32'd1);
        bus.en_i = 1'b0;
        bus.rd_i = 1'b1;
        tick();
        check("t5_dat", 32'(bus.dat_o), 32'h5A5A5A);
        check("t5_vld", 32'(bus.vld_o), 32'd1);
        tick();
        check("t5_empty_vld", 32'(bus.vld_o),   32'd0);
        check("t5_empty_lvl", 32'(bus.level_o), 32'd0);
        check("t5_empty",     32'(bus.empty_o), 32'd1);
        check("t5_hold",      32'(bus.dat_o),   32'h5A5A5A);
        bus.rd_i = 1'b0;

        // Asynchronous reset mid-period with three samples buffered.
        bus.dly_i = 3'd0;
        bus.en_i  = 1'b1;
        for (int k = 1; k <= 15; k++) tick();
        check("t6_level3", 32'(bus.level_o), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check("t6_empty", 32'(bus.empty_o), 32'd1);
        check("t6_level", 32'(bus.level_o), 32'd0);
        check("t6_full",  32'(bus.full_o),  32'd0);
        check("t6_oflow", 32'(bus.oflow_o), 32'd0);
        check("t6_vld",   32'(bus.vld_o),   32'd0);
        check("t6_stb",   32'(bus.stb_o),   32'd0);
        check("t6_dat",   32'(bus.dat_o),   32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("t6_first_stb", 32'(bus.stb_o),   32'd1);
        check("t6_first_lvl", 32'(bus.level_o), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tart_capture.md
# tart_capture

Parametrised antenna-capture front-end: synchronises the raw radio-data bus into the 6× fabric clock, samples it once per receiver period at a programmable phase, optionally substitutes a counter test pattern, and buffers samples in an on-chip FIFO for the storage scheduler. It generalises fixed-width 24-antenna capture with 3-bit sample delay to any antenna count, clock ratio and depth, and adds overflow detection, flush and level reporting.

## Interface
- AXNUM, 24: antenna channels (sample width)
- RATIO, 6: fabric clocks per receiver sample
- RBITS, 3: phase-select width; 2^RBITS ≥ RATIO
- ABITS, 9: FIFO address width; depth = 2^ABITS
- clk_i  in  1  fabric clock (16.368 MHz × RATIO)
- rst_i  in  1  asynchronous, active-high reset
- en_i  in  1  capture enable
- dbg_i  in  1  1 = counter test pattern instead of antenna data
- dly_i  in  RBITS  sample phase within each receiver period
- clr_i  in  1  synchronous flush: empties FIFO, clears overflow and pattern counter
- ant_i  in  AXNUM  raw antenna pins, asynchronous to clk_i
- rd_i  in  1  FIFO read request
- dat_o  out  AXNUM  read data
- vld_o  out  1  dat_o valid strobe
- empty_o  out  1  FIFO empty
- full_o  out  1  FIFO full
- level_o  out  ABITS+1  FIFO occupancy
- oflow_o  out  1  sticky overflow flag
- stb_o  out  1  capture strobe, one cycle per accepted/attempted sample

## Operation
- Synchroniser: ant_i → s1 → s2, two flops, no reset dependency on data path.
- Phase counter ph: 0..RATIO-1, wraps; held at 0 while en_i=0.
- At ph==0, latch dly_r ← min(dly_i, RATIO-1) and dbg_r ← dbg_i; changes mid-period have no effect until next ph==0.
- Capture event: en_i=1 and ph==dly_r. stb_o pulses. Sample = dbg_r ? pat : s2; pat (AXNUM bits) increments after each capture event in debug mode, wraps at 2^AXNUM-1 → 0.
- Write: on capture event, if !full or rd_i accepted same cycle, write sample; else drop and set oflow_o.
- Read: rd_i with !empty pops head; rd_i while empty ignored (no vld_o, no state change).
- Simultaneous write+read: level unchanged, both succeed, including at full and at empty (empty case: read ignored, write proceeds).
- clr_i: pointers, level, oflow_o, pat → 0; a capture in the same cycle is discarded; clr_i has priority over rd_i.
- en_i deassert: captures stop, ph → 0; FIFO contents, oflow_o, pat preserved.
- Reset values: all outputs 0 except empty_o=1; ph=0, dly_r=0, dbg_r=0, pat=0.

## Timing
- Pin-to-capture latency: 2 cycles synchroniser, then sampled at edge where ph==dly_r.
- Write at the capture edge; empty_o, full_o, level_o are registered and reflect it in the following cycle.
- Read: rd_i sampled at edge k → dat_o, vld_o valid during cycle k+1 (vld_o one cycle); level_o decrements at edge k.
- dat_o holds last read value when vld_o=0.
- Pointers wrap modulo 2^ABITS; full = level==2^ABITS.
- Reset mid-operation: asynchronous clear of all state; no partial write survives.

## Structure
- Shared include (tart config header): AXNUM, RATIO, RBITS, ABITS defaults, so scheduler and SPI readback agree on widths.
- Sub-module tart_capture_fifo: synchronous FIFO, block-RAM-inferred memory, registered read port, level/full/empty; capture logic (sync, phase, pattern, overflow) stays in tart_capture.
- Estimated 200–300 lines total.

## Test plan
- Real data, dly_i=2, en_i=1, ant_i=24'hA5A5A5 held: stb_o every 6 cycles at ph=2; reading returns A5A5A5, level_o counts 1,2,3 between reads.
- Debug mode, dly_i=0, 5 captures: reads return 0,1,2,3,4 in order; dly_i changed to 4 mid-period takes effect only from next ph==0.
- ABITS=2, no reads, 5 captures: level_o=4, full_o=1, oflow_o=1 after 5th, reads return first four samples only; clr_i → level 0, empty_o=1, oflow_o=0.
- Full FIFO with rd_i asserted on a capture edge: level_o stays 4, oflow_o stays 0, new sample appears last in read order.
- dly_i=7 with RATIO=6: capture occurs at ph=5; rd_i on empty FIFO: no vld_o, level_o stays 0.
- rst_i asserted asynchronously mid-period with 3 samples buffered: all outputs immediately 0, empty_o=1; after release, first capture at ph==0 (dly_r=0).
